// File: rtl/smc_avm_bridge_v2.sv
// SMC host bus to Avalon-MM master bridge: posted-write FIFO, reads ordered
// behind pending writes, and a read timeout so the host bus never hangs.
module smc_avm_bridge_v2 #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 22,
  parameter int unsigned       NUM_CS     = 4,
  parameter int unsigned       TAG_SHIFT  = 28,
  parameter int unsigned       WBUF_DEPTH = 4,
  parameter int unsigned       RD_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(32'hDEADBEEF)
) (
  input  logic                          q_clock,
  input  logic                          q_reset,
  input  logic [NUM_CS-1:0]             host_csn,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W/8-1:0]           host_ben,
  input  logic                          host_rdn,
  input  logic                          host_wrn,
  input  logic [DATA_W-1:0]             host_data_i,
  output logic [DATA_W-1:0]             host_data_o,
  output logic                          host_data_oe,
  output logic                          host_waitn,
  output logic [31:0]                   avm_address,
  output logic [DATA_W/8-1:0]           avm_byteenable,
  output logic [DATA_W-1:0]             avm_writedata,
  output logic                          avm_write,
  output logic                          avm_read,
  input  logic [DATA_W-1:0]             avm_readdata,
  input  logic                          avm_readdatavalid,
  input  logic                          avm_waitrequest,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
  output logic                          rd_timeout_err,
  input  logic                          err_clear
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned BYTE_SH = $clog2(BE_W);
  localparam int unsigned PTR_W   = $clog2(WBUF_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned TMO_W   = $clog2(RD_TIMEOUT + 1);
  localparam int unsigned ENT_W   = 32 + BE_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_FLUSH, S_RD_REQ, S_RD_WAIT, S_RD_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CS-1:0] csn_s1_q, csn_s2_q;
  logic              rdn_s1_q, rdn_s2_q;
  logic              wrn_s1_q, wrn_s2_q, wrn_s3_q;
  logic [ADDR_W-1:0] addr_s_q;
  logic [BE_W-1:0]   ben_s_q;
  logic [DATA_W-1:0] data_s_q;

  logic [ENT_W-1:0]  mem_q [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;

  logic [31:0]       avm_address_q, avm_address_d;
  logic [BE_W-1:0]   avm_byteenable_q, avm_byteenable_d;
  logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;
  logic              avm_write_q, avm_write_d, avm_read_q, avm_read_d;
  logic [DATA_W-1:0] host_data_o_q, host_data_o_d;
  logic              host_data_oe_q, host_data_oe_d;
  logic              host_waitn_q, host_waitn_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [NUM_CS-1:0] rd_csn_q, rd_csn_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]       rd_avm_addr_q, rd_avm_addr_d;
  logic [BE_W-1:0]   rd_be_q, rd_be_d;

  logic [ENT_W-1:0]  wr_ent_q, wr_ent_d;
  logic              wr_ok_q, wr_ok_d;
  logic              pend_q, pend_d;
  logic              wait_full_q, wait_full_d;

  logic              cs_valid;
  int unsigned       cs_idx;
  logic [31:0]       map_addr;
  logic [ENT_W-1:0]  head;
  logic              full, empty;
  logic              rd_req, wr_fall, wr_rise;
  logic              pop, push_req, do_push, err_set;

  // Exactly one chip select low is an access; anything else is ignored.
  always_comb begin
    int unsigned zeros;
    zeros  = 0;
    cs_idx = 0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (!csn_s2_q[i]) begin
        zeros  = zeros + 1;
        cs_idx = i;
      end
    end
    cs_valid = (zeros == 1);
    map_addr = 32'((cs_idx + 1) << TAG_SHIFT) | (32'(addr_s_q) << BYTE_SH);
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == LVL_W'(WBUF_DEPTH));
  assign empty = (count_q == '0);

  assign rd_req  = !rdn_s2_q && cs_valid;
  assign wr_fall = !wrn_s2_q && wrn_s3_q;
  assign wr_rise = wrn_s2_q && !wrn_s3_q;

  always_comb begin
    state_d          = state_q;
    avm_address_d    = avm_address_q;
    avm_byteenable_d = avm_byteenable_q;
    avm_writedata_d  = avm_writedata_q;
    avm_write_d      = avm_write_q;
    avm_read_d       = avm_read_q;
    host_data_o_d    = host_data_o_q;
    tmo_d            = tmo_q;
    rd_csn_d         = rd_csn_q;
    rd_addr_d        = rd_addr_q;
    rd_avm_addr_d    = rd_avm_addr_q;
    rd_be_d          = rd_be_q;
    wr_ent_d         = wr_ent_q;
    wr_ok_d          = wr_ok_q;
    wait_full_d      = wait_full_q;
    pop              = 1'b0;
    err_set          = 1'b0;

    // Hold the captured write while a deferred push is outstanding.
    if (!wrn_s2_q && !pend_q) begin
      wr_ok_d = cs_valid;
      if (cs_valid) wr_ent_d = {map_addr, ~ben_s_q, data_s_q};
    end

    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          rd_csn_d      = csn_s2_q;
          rd_addr_d     = addr_s_q;
          rd_avm_addr_d = map_addr;
          rd_be_d       = ~ben_s_q;
          if (!empty) begin
            state_d          = S_RD_FLUSH;
            avm_write_d      = 1'b1;
            avm_address_d    = head[ENT_W-1 -: 32];
            avm_byteenable_d = head[DATA_W +: BE_W];
            avm_writedata_d  = head[DATA_W-1:0];
          end else begin
            state_d          = S_RD_REQ;
            avm_read_d       = 1'b1;
            avm_address_d    = map_addr;
            avm_byteenable_d = ~ben_s_q;
          end
        end else if (!empty) begin
          state_d          = S_WR;
          avm_write_d      = 1'b1;
          avm_address_d    = head[ENT_W-1 -: 32];
          avm_byteenable_d = head[DATA_W +: BE_W];
          avm_writedata_d  = head[DATA_W-1:0];
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          pop         = 1'b1;
          avm_write_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_RD_FLUSH: begin
        if (avm_write_q) begin
          if (!avm_waitrequest) begin
            pop         = 1'b1;
            avm_write_d = 1'b0;
          end
        end else if (!empty) begin
          avm_write_d      = 1'b1;
          avm_address_d    = head[ENT_W-1 -: 32];
          avm_byteenable_d = head[DATA_W +: BE_W];
          avm_writedata_d  = head[DATA_W-1:0];
        end else begin
          state_d          = S_RD_REQ;
          avm_read_d       = 1'b1;
          avm_address_d    = rd_avm_addr_q;
          avm_byteenable_d = rd_be_q;
        end
      end
      S_RD_REQ: begin
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          tmo_d      = '0;
          state_d    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          host_data_o_d = avm_readdata;
          state_d       = S_RD_HOLD;
        end else if (tmo_q == TMO_W'(RD_TIMEOUT)) begin
          host_data_o_d = ERR_DATA;
          err_set       = 1'b1;
          state_d       = S_RD_HOLD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RD_HOLD: begin
        if (rdn_s2_q || (csn_s2_q != rd_csn_q) || (addr_s_q != rd_addr_q))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A push into a full FIFO only proceeds when a pop frees the slot this cycle.
    push_req = (wr_rise && wr_ok_q) || pend_q;
    do_push  = push_req && (!full || pop);
    pend_d   = push_req && !do_push;

    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + LVL_W'(do_push) - LVL_W'(pop);

    if (wr_fall && full && !pop)               wait_full_d = 1'b1;
    else if (count_d != LVL_W'(WBUF_DEPTH))    wait_full_d = 1'b0;

    err_d = err_q;
    if (err_clear) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;

    host_data_oe_d = (state_d == S_RD_HOLD) && !rdn_s2_q && cs_valid &&
                     (csn_s2_q == rd_csn_q);
    host_waitn_d   = !(wait_full_d || pend_d ||
                       (state_d == S_RD_FLUSH) || (state_d == S_RD_REQ) ||
                       (state_d == S_RD_WAIT) ||
                       (rd_req && (state_d != S_RD_HOLD)));
  end

  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      csn_s1_q         <= '1;
      csn_s2_q         <= '1;
      rdn_s1_q         <= 1'b1;
      rdn_s2_q         <= 1'b1;
      wrn_s1_q         <= 1'b1;
      wrn_s2_q         <= 1'b1;
      wrn_s3_q         <= 1'b1;
      addr_s_q         <= '0;
      ben_s_q          <= '1;
      data_s_q         <= '0;
      state_q          <= S_IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      avm_address_q    <= '0;
      avm_byteenable_q <= '0;
      avm_writedata_q  <= '0;
      avm_write_q      <= 1'b0;
      avm_read_q       <= 1'b0;
      host_data_o_q    <= '0;
      host_data_oe_q   <= 1'b0;
      host_waitn_q     <= 1'b1;
      err_q            <= 1'b0;
      tmo_q            <= '0;
      rd_csn_q         <= '1;
      rd_addr_q        <= '0;
      rd_avm_addr_q    <= '0;
      rd_be_q          <= '0;
      wr_ent_q         <= '0;
      wr_ok_q          <= 1'b0;
      pend_q           <= 1'b0;
      wait_full_q      <= 1'b0;
    end else begin
      csn_s1_q         <= host_csn;
      csn_s2_q         <= csn_s1_q;
      rdn_s1_q         <= host_rdn;
      rdn_s2_q         <= rdn_s1_q;
      wrn_s1_q         <= host_wrn;
      wrn_s2_q         <= wrn_s1_q;
      wrn_s3_q         <= wrn_s2_q;
      addr_s_q         <= host_addr;
      ben_s_q          <= host_ben;
      data_s_q         <= host_data_i;
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      avm_address_q    <= avm_address_d;
      avm_byteenable_q <= avm_byteenable_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_write_q      <= avm_write_d;
      avm_read_q       <= avm_read_d;
      host_data_o_q    <= host_data_o_d;
      host_data_oe_q   <= host_data_oe_d;
      host_waitn_q     <= host_waitn_d;
      err_q            <= err_d;
      tmo_q            <= tmo_d;
      rd_csn_q         <= rd_csn_d;
      rd_addr_q        <= rd_addr_d;
      rd_avm_addr_q    <= rd_avm_addr_d;
      rd_be_q          <= rd_be_d;
      wr_ent_q         <= wr_ent_d;
      wr_ok_q          <= wr_ok_d;
      pend_q           <= pend_d;
      wait_full_q      <= wait_full_d;
    end
  end

  always_ff @(posedge q_clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_ent_q;
  end

  assign host_data_o    = host_data_o_q;
  assign host_data_oe   = host_data_oe_q;
  assign host_waitn     = host_waitn_q;
  assign avm_address    = avm_address_q;
  assign avm_byteenable = avm_byteenable_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_write      = avm_write_q;
  assign avm_read       = avm_read_q;
  assign wbuf_level     = count_q;
  assign rd_timeout_err = err_q;

endmodule

// File: tb/tb_smc_avm_bridge_v2.sv
// Directed bench for smc_avm_bridge_v2: host-side write/read tasks, an Avalon
// slave responder and an acceptance monitor; expected values are hand-computed.
module tb_smc_avm_bridge_v2;

  logic        q_clock = 1'b0;
  logic        q_reset;
  logic [3:0]  host_csn;
  logic [21:0] host_addr;
  logic [3:0]  host_ben;
  logic        host_rdn, host_wrn;
  logic [31:0] host_data_i, host_data_o;
  logic        host_data_oe, host_waitn;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_write, avm_read, avm_readdatavalid, avm_waitrequest;
  logic [2:0]  wbuf_level;
  logic        rd_timeout_err, err_clear;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr_log[$];
  logic [3:0]  wr_be_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] rd_addr_log[$];
  int          rd_start_wrcnt = -1;
  logic        rd_prev = 1'b0;
  logic [2:0]  lvl_max = '0;

  logic        rsp_en = 1'b0;
  logic [31:0] rsp_data = '0;
  int          rdv_cnt;

  smc_avm_bridge_v2 #(.WBUF_DEPTH(4), .RD_TIMEOUT(255)) dut (
    .q_clock(q_clock), .q_reset(q_reset),
    .host_csn(host_csn), .host_addr(host_addr), .host_ben(host_ben),
    .host_rdn(host_rdn), .host_wrn(host_wrn), .host_data_i(host_data_i),
    .host_data_o(host_data_o), .host_data_oe(host_data_oe), .host_waitn(host_waitn),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_write(avm_write), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest), .wbuf_level(wbuf_level),
    .rd_timeout_err(rd_timeout_err), .err_clear(err_clear)
  );

  always #5 q_clock = ~q_clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Records every Avalon transfer at the edge where it is accepted.
  always @(posedge q_clock) begin
    if (avm_write && !avm_waitrequest) begin
      wr_addr_log.push_back(avm_address);
      wr_be_log.push_back(avm_byteenable);
      wr_data_log.push_back(avm_writedata);
    end
    if (avm_read && !avm_waitrequest) rd_addr_log.push_back(avm_address);
    if (avm_read && !rd_prev) rd_start_wrcnt <= wr_addr_log.size();
    rd_prev <= avm_read;
    if (wbuf_level > lvl_max) lvl_max <= wbuf_level;
  end

  // Read slave: returns rsp_data three cycles after acceptance when enabled.
  initial begin
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    rdv_cnt           = 0;
    forever begin
      @(posedge q_clock);
      if (avm_read && !avm_waitrequest && rsp_en) begin
        repeat (3) @(negedge q_clock);
        avm_readdata      = rsp_data;
        avm_readdatavalid = 1'b1;
        rdv_cnt++;
        @(negedge q_clock);
        avm_readdatavalid = 1'b0;
      end
    end
  end

  task automatic host_write(input logic [3:0] csn, input logic [21:0] a,
                            input logic [31:0] d, input logic [3:0] ben,
                            output logic saw_wait);
    int n;
    @(negedge q_clock);
    host_csn = csn; host_addr = a; host_data_i = d; host_ben = ben; host_wrn = 1'b0;
    saw_wait = 1'b0;
    repeat (4) begin
      @(negedge q_clock);
      if (!host_waitn) saw_wait = 1'b1;
    end
    n = 0;
    while (!host_waitn && n < 400) begin
      @(negedge q_clock);
      n++;
    end
    check_eq("wr_wait_release", host_waitn, 1'b1);
    host_wrn = 1'b1;
    repeat (2) @(negedge q_clock);
    host_csn = '1;
    repeat (2) @(negedge q_clock);
  endtask

  task automatic host_read(input logic [3:0] csn, input logic [21:0] a, input logic [3:0] ben,
                           output logic [31:0] d, output logic oe);
    int n;
    @(negedge q_clock);
    host_csn = csn; host_addr = a; host_ben = ben; host_rdn = 1'b0;
    repeat (3) @(negedge q_clock);
    check_eq("rd_waitn_low", host_waitn, 1'b0);
    n = 0;
    while (!host_waitn && n < 400) begin
      @(negedge q_clock);
      n++;
    end
    check_eq("rd_done", host_waitn, 1'b1);
    d  = host_data_o;
    oe = host_data_oe;
    host_rdn = 1'b1;
    repeat (2) @(negedge q_clock);
    host_csn = '1;
    repeat (4) @(negedge q_clock);
  endtask

  initial begin
    logic        sw [5];
    logic        sw1, oe_v, wmin, oemax, rdmax;
    logic [31:0] rdata;
    int          base, rdv0, rdn0, n;

    q_reset = 1'b1;
    host_csn = '1; host_addr = '0; host_ben = '1; host_rdn = 1'b1; host_wrn = 1'b1;
    host_data_i = '0; avm_waitrequest = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge q_clock);
    check_eq("rst_write", avm_write, 1'b0);
    check_eq("rst_read", avm_read, 1'b0);
    check_eq("rst_waitn", host_waitn, 1'b1);
    check_eq("rst_oe", host_data_oe, 1'b0);
    check_eq("rst_level", wbuf_level, 3'd0);
    check_eq("rst_err", rd_timeout_err, 1'b0);
    check_eq("rst_addr", avm_address, 32'h0);
    check_eq("rst_data_o", host_data_o, 32'h0);
    q_reset = 1'b0;
    repeat (2) @(negedge q_clock);

    // Single posted write on CS1.
    host_write(4'b1101, 22'h000010, 32'hA5A5_0001, 4'b0000, sw1);
    repeat (8) @(negedge q_clock);
    check_eq("w1_count", wr_addr_log.size(), 1);
    check_eq("w1_addr", wr_addr_log[0], 32'h2000_0040);
    check_eq("w1_be", wr_be_log[0], 4'hF);
    check_eq("w1_data", wr_data_log[0], 32'hA5A5_0001);
    check_eq("w1_nowait", sw1, 1'b0);

    // Five writes into a 4-deep FIFO with the slave stalled.
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++)
      host_write(4'b1011, 22'h100 + 22'(k), 32'h5000_0000 + 32'(k), 4'b0101, sw[k]);
    check_eq("w5_level_full", wbuf_level, 3'd4);
    fork
      host_write(4'b1011, 22'h104, 32'h5000_0004, 4'b0101, sw[4]);
      begin repeat (24) @(negedge q_clock); avm_waitrequest = 1'b0; end
    join
    repeat (30) @(negedge q_clock);
    check_eq("w5_count", wr_addr_log.size(), 6);
    for (int k = 0; k < 5; k++) begin
      check_eq("w5_addr", wr_addr_log[1+k], 32'h3000_0400 + 32'(4*k));
      check_eq("w5_data", wr_data_log[1+k], 32'h5000_0000 + 32'(k));
      check_eq("w5_be", wr_be_log[1+k], 4'b1010);
    end
    check_eq("w5_wait_4th", sw[3], 1'b0);
    check_eq("w5_wait_5th", sw[4], 1'b1);
    check_eq("w5_lvl_peak", lvl_max, 3'd4);

    // Read ordered behind two stalled posted writes.
    avm_waitrequest = 1'b1;
    host_write(4'b1110, 22'h020, 32'hC0DE_0020, 4'b0000, sw1);
    host_write(4'b1110, 22'h021, 32'hC0DE_0021, 4'b0000, sw1);
    base = wr_addr_log.size();
    rdv0 = rdv_cnt;
    rsp_en = 1'b1; rsp_data = 32'h1234_5678;
    fork
      host_read(4'b1110, 22'h000003, 4'b0000, rdata, oe_v);
      begin repeat (10) @(negedge q_clock); avm_waitrequest = 1'b0; end
    join
    check_eq("r_order", rd_start_wrcnt, base + 2);
    check_eq("r_wr0_addr", wr_addr_log[base], 32'h1000_0080);
    check_eq("r_wr1_data", wr_data_log[base+1], 32'hC0DE_0021);
    check_eq("r_addr", rd_addr_log[rd_addr_log.size()-1], 32'h1000_000C);
    check_eq("r_data", rdata, 32'h1234_5678);
    check_eq("r_oe", oe_v, 1'b1);
    check_eq("r_valid_before_waitn", rdv_cnt, rdv0 + 1);
    check_eq("r_oe_after", host_data_oe, 1'b0);

    // Read that never completes: timeout 256 edges after acceptance.
    rsp_en = 1'b0;
    @(negedge q_clock);
    host_csn = 4'b0111; host_addr = 22'h55; host_ben = 4'b0000; host_rdn = 1'b0;
    n = 0;
    while (!avm_read && n < 20) begin @(negedge q_clock); n++; end
    check_eq("to_rd_issued", avm_read, 1'b1);
    @(posedge q_clock);
    repeat (255) @(posedge q_clock);
    @(negedge q_clock);
    check_eq("to_wait_255", host_waitn, 1'b0);
    check_eq("to_err_255", rd_timeout_err, 1'b0);
    @(negedge q_clock);
    check_eq("to_wait_256", host_waitn, 1'b1);
    check_eq("to_data", host_data_o, 32'hDEAD_BEEF);
    check_eq("to_err", rd_timeout_err, 1'b1);
    check_eq("to_oe", host_data_oe, 1'b1);
    host_rdn = 1'b1; host_csn = '1;
    repeat (4) @(negedge q_clock);
    check_eq("to_err_sticky", rd_timeout_err, 1'b1);
    check_eq("to_oe_off", host_data_oe, 1'b0);
    err_clear = 1'b1;
    @(negedge q_clock);
    err_clear = 1'b0;
    check_eq("to_err_clear", rd_timeout_err, 1'b0);

    // Two chip selects low: no access at all.
    rdn0 = rd_addr_log.size();
    wmin = 1'b1; oemax = 1'b0; rdmax = 1'b0;
    @(negedge q_clock);
    host_csn = 4'b1100; host_addr = 22'h7; host_rdn = 1'b0;
    repeat (12) begin
      @(negedge q_clock);
      wmin  = wmin & host_waitn;
      oemax = oemax | host_data_oe;
      rdmax = rdmax | avm_read;
    end
    check_eq("mcs_waitn", wmin, 1'b1);
    check_eq("mcs_oe", oemax, 1'b0);
    check_eq("mcs_read", rdmax, 1'b0);
    check_eq("mcs_rdlog", rd_addr_log.size(), rdn0);
    host_rdn = 1'b1; host_csn = '1;
    repeat (4) @(negedge q_clock);

    // Reset while a write is stalled in flight.
    avm_waitrequest = 1'b1;
    host_write(4'b1101, 22'h040, 32'hBAD0_0040, 4'b0000, sw1);
    n = 0;
    while (!avm_write && n < 20) begin @(negedge q_clock); n++; end
    check_eq("rst_mid_wr_active", avm_write, 1'b1);
    base = wr_addr_log.size();
    q_reset = 1'b1;
    #1;
    check_eq("rst_mid_write", avm_write, 1'b0);
    check_eq("rst_mid_level", wbuf_level, 3'd0);
    check_eq("rst_mid_waitn", host_waitn, 1'b1);
    @(negedge q_clock);
    q_reset = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (20) @(negedge q_clock);
    check_eq("rst_no_reissue", wr_addr_log.size(), base);
    check_eq("rst_post_write", avm_write, 1'b0);
    check_eq("rst_post_level", wbuf_level, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
